// File: rtl/uart_fifo_periph.sv
// uart_fifo_periph: memory-mapped 8N1 UART with TX/RX FIFOs, status/ctrl registers and level irq
module uart_fifo_periph_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic [7:0] i_din,
  output logic [7:0] o_dout,
  output logic       o_empty,
  output logic       o_full
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          w_wen, w_ren;
  assign o_empty = r_cnt == '0;
  assign o_full  = r_cnt == (AW+1)'(DEPTH);
  assign w_ren   = i_pop & ~o_empty;
  // a pop in the same cycle frees the slot, so a full FIFO may still accept
  assign w_wen   = i_push & (~o_full | w_ren);
  assign o_dout  = r_mem[r_rp];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= r_wp + AW'(w_wen);
      r_rp  <= r_rp + AW'(w_ren);
      r_cnt <= r_cnt + (AW+1)'(w_wen) - (AW+1)'(w_ren);
    end
  always_ff @(posedge clk)
    if (w_wen) r_mem[r_wp] <= i_din;
endmodule

module uart_fifo_periph #(
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0020,
  parameter int          BAUD_DIV   = 27,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        irq
);
  localparam int BW = $clog2(BAUD_DIV + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  typedef enum logic [2:0] {T_IDLE, T_WAIT, T_START, T_DATA, T_STOP} tx_st_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAITHI} rx_st_t;
  tx_st_t r_tx_st, w_tx_nx;
  rx_st_t r_rx_st, w_rx_nx;
  logic [BW-1:0] r_baud;
  logic [3:0] r_tx_tk, r_rx_tk;
  logic [2:0] r_tx_bit, r_rx_bit, r_rx_sync;
  logic [7:0] r_tx_sh, r_rx_sh, w_tx_head, w_rx_head;
  logic [1:0] r_ctrl;
  logic r_ovr, r_fe, r_irq;
  logic w_sel, w_tick, w_tx_end, w_rx_end, w_tx_pop, w_rx_push, w_fe_set, w_line, w_fall;
  logic w_tx_empty, w_tx_full, w_rx_empty, w_rx_full, w_tx_idle;
  logic w_tx_wr, w_ctrl_wr, w_rx_rd, w_st_rd, w_unused;
  logic [1:0] w_idx;
  assign w_sel     = addr[31:4] == BASE_ADDR[31:4];
  assign w_idx     = addr[3:2];
  assign w_tx_wr   = wr & w_sel & (w_idx == 2'd0);
  assign w_ctrl_wr = wr & w_sel & (w_idx == 2'd3);
  assign w_rx_rd   = rd & w_sel & (w_idx == 2'd1);
  assign w_st_rd   = rd & w_sel & (w_idx == 2'd2);
  assign w_unused  = ^{addr[1:0], wdata[31:8]};
  assign w_tick    = r_baud == BAUD_LAST;
  assign w_tx_end  = w_tick & (r_tx_tk == 4'd15);
  assign w_rx_end  = w_tick & (r_rx_tk == 4'd15);
  assign w_line    = r_rx_sync[1];
  assign w_fall    = r_rx_sync[2] & ~r_rx_sync[1];
  assign w_tx_idle = w_tx_empty & (r_tx_st == T_IDLE);
  assign irq       = r_irq;
  assign rdata = !(rd && w_sel) ? 32'd0 :
                 w_idx == 2'd1 ? {24'd0, w_rx_empty ? 8'd0 : w_rx_head} :
                 w_idx == 2'd2 ? {27'd0, r_fe, r_ovr, ~w_rx_empty, w_tx_idle, w_tx_full} :
                 w_idx == 2'd3 ? {30'd0, r_ctrl} : 32'd0;
  uart_fifo_periph_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .i_push(w_tx_wr & ~w_tx_full), .i_pop(w_tx_pop),
    .i_din(wdata[7:0]), .o_dout(w_tx_head), .o_empty(w_tx_empty), .o_full(w_tx_full));
  uart_fifo_periph_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .i_push(w_rx_push), .i_pop(w_rx_rd),
    .i_din(r_rx_sh), .o_dout(w_rx_head), .o_empty(w_rx_empty), .o_full(w_rx_full));
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_baud    <= '0;
      r_tx_st   <= T_IDLE;
      r_tx_tk   <= '0;
      r_tx_bit  <= '0;
      r_tx_sh   <= '0;
      r_rx_st   <= R_IDLE;
      r_rx_tk   <= '0;
      r_rx_bit  <= '0;
      r_rx_sh   <= '0;
      r_rx_sync <= 3'b111;
      r_ctrl    <= '0;
      r_ovr     <= 1'b0;
      r_fe      <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_baud    <= w_tick ? '0 : r_baud + BW'(1);
      r_tx_st   <= w_tx_nx;
      r_tx_tk   <= (r_tx_st == T_IDLE || r_tx_st == T_WAIT) ? 4'd0 : r_tx_tk + {3'd0, w_tick};
      r_tx_bit  <= r_tx_st != T_DATA ? 3'd0 : r_tx_bit + {2'd0, w_tx_end};
      r_tx_sh   <= w_tx_pop ? w_tx_head : (r_tx_st == T_DATA && w_tx_end) ? r_tx_sh >> 1 : r_tx_sh;
      r_rx_sync <= {r_rx_sync[1:0], uart_rx};
      r_rx_st   <= w_rx_nx;
      r_rx_tk   <= (r_rx_st == R_IDLE || r_rx_st == R_WAITHI ||
                    (r_rx_st == R_START && w_tick && r_rx_tk == 4'd7)) ? 4'd0 : r_rx_tk + {3'd0, w_tick};
      r_rx_bit  <= r_rx_st != R_DATA ? 3'd0 : r_rx_bit + {2'd0, w_rx_end};
      r_rx_sh   <= (r_rx_st == R_DATA && w_rx_end) ? {w_line, r_rx_sh[7:1]} : r_rx_sh;
      r_ctrl    <= w_ctrl_wr ? wdata[1:0] : r_ctrl;
      // a set event in the same cycle as a STATUS read wins over the clear
      r_ovr     <= (w_rx_push & w_rx_full & ~w_rx_rd) | (r_ovr & ~w_st_rd);
      r_fe      <= w_fe_set | (r_fe & ~w_st_rd);
      r_irq     <= (r_ctrl[0] & ~w_rx_empty) | (r_ctrl[1] & w_tx_idle);
    end
  always_comb begin
    w_tx_nx = r_tx_st;
    case (r_tx_st)
      T_IDLE:  w_tx_nx = w_tx_empty ? T_IDLE : T_WAIT;
      T_WAIT:  w_tx_nx = w_tick ? T_START : T_WAIT;
      T_START: w_tx_nx = w_tx_end ? T_DATA : T_START;
      T_DATA:  w_tx_nx = (w_tx_end && r_tx_bit == 3'd7) ? T_STOP : T_DATA;
      T_STOP:  w_tx_nx = !w_tx_end ? T_STOP : w_tx_empty ? T_IDLE : T_START;
      default: w_tx_nx = T_IDLE;
    endcase
  end
  always_comb begin
    w_tx_pop = ~w_tx_empty & ((r_tx_st == T_IDLE) | (r_tx_st == T_STOP & w_tx_end));
    uart_tx  = r_tx_st == T_START ? 1'b0 : r_tx_st == T_DATA ? r_tx_sh[0] : 1'b1;
  end
  always_comb begin
    w_rx_nx = r_rx_st;
    case (r_rx_st)
      R_IDLE:   w_rx_nx = w_fall ? R_START : R_IDLE;
      R_START:  w_rx_nx = !(w_tick && r_rx_tk == 4'd7) ? R_START : w_line ? R_IDLE : R_DATA;
      R_DATA:   w_rx_nx = (w_rx_end && r_rx_bit == 3'd7) ? R_STOP : R_DATA;
      R_STOP:   w_rx_nx = !w_rx_end ? R_STOP : w_line ? R_IDLE : R_WAITHI;
      R_WAITHI: w_rx_nx = w_line ? R_IDLE : R_WAITHI;
      default:  w_rx_nx = R_IDLE;
    endcase
  end
  always_comb begin
    w_rx_push = (r_rx_st == R_STOP) & w_rx_end & w_line;
    w_fe_set  = (r_rx_st == R_STOP) & w_rx_end & ~w_line;
  end
endmodule

// File: tb/tb_uart_fifo_periph.sv
// tb_uart_fifo_periph: scoreboard bench for bus reads and serial TX bytes of uart_fifo_periph
module tb_uart_fifo_periph;
  localparam logic [31:0] BASE = 32'h4000_0020;
  typedef struct { string nm; logic [31:0] v; } exp_t;
  logic clk = 1'b0, reset, rd, wr, uart_rx, uart_tx, irq;
  logic [31:0] addr, wdata, rdata;
  exp_t q_rd[$];
  logic [7:0] q_tx[$];
  exp_t e;
  logic [7:0] mon_b;
  int n_checks = 0, n_errors = 0;

  uart_fifo_periph #(.BASE_ADDR(BASE), .BAUD_DIV(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .uart_rx(uart_rx), .uart_tx(uart_tx), .irq(irq));

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd_at(input logic [31:0] a, input logic [31:0] exp, input string nm);
    q_rd.push_back('{nm, exp});
    addr = a;
    rd = 1'b1;
    clks(1);
    rd = 1'b0;
  endtask

  task automatic rd_reg(input logic [1:0] idx, input logic [31:0] exp, input string nm);
    rd_at(BASE + {28'd0, idx, 2'b00}, exp, nm);
  endtask

  task automatic wr_reg(input logic [1:0] idx, input logic [31:0] d);
    addr = BASE + {28'd0, idx, 2'b00};
    wdata = d;
    wr = 1'b1;
    clks(1);
    wr = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    clks(32);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      clks(32);
    end
    uart_rx = stop;
    clks(32);
    uart_rx = 1'b1;
    clks(8);
  endtask

  // bus read monitor: every read cycle must match the next queued expectation
  always @(negedge clk)
    if (rd) begin
      if (q_rd.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_read: got %h expected no read", rdata);
      end else begin
        e = q_rd.pop_front();
        cmp(e.nm, rdata, e.v);
      end
    end

  // serial monitor: 32 clk per bit, sampled mid-bit from the start edge
  initial forever begin
    @(negedge uart_tx);
    clks(16);
    cmp("tx_start_bit", {31'd0, uart_tx}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      clks(32);
      mon_b[i] = uart_tx;
    end
    clks(32);
    cmp("tx_stop_bit", {31'd0, uart_tx}, 32'd1);
    if (q_tx.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_tx_byte: got %h expected none", mon_b);
    end else cmp("tx_byte", {24'd0, mon_b}, {24'd0, q_tx.pop_front()});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; uart_rx = 1'b1;
    clks(3);
    reset = 1'b1;
    clks(2);
    addr = BASE + 32'h8;
    #1;
    cmp("rdata_rd0", rdata, 32'd0);
    cmp("uart_tx_reset", {31'd0, uart_tx}, 32'd1);
    cmp("irq_reset", {31'd0, irq}, 32'd0);
    clks(1);
    rd_reg(2, 32'h2, "status_reset");
    rd_reg(1, 32'h0, "rxdata_empty");
    rd_reg(3, 32'h0, "ctrl_reset");
    rd_at(BASE + 32'h10, 32'h0, "unselected_read");
    q_tx.push_back(8'hA5);
    wr_reg(0, 32'hA5);
    clks(100);
    rd_reg(2, 32'h0, "status_tx_busy");
    clks(250);
    rd_reg(2, 32'h2, "status_tx_done");
    for (int i = 1; i <= 6; i++) begin
      if (i <= 5) q_tx.push_back(8'(i * 8'h11));
      wr_reg(0, 32'(i * 8'h11));
    end
    rd_reg(2, 32'h1, "status_tx_full");
    clks(1700);
    rd_reg(2, 32'h2, "status_tx_drained");
    wr_reg(2, 32'hFF);
    wr_reg(1, 32'hFF);
    rd_reg(2, 32'h2, "status_ro_write");
    send_rx(8'h3C, 1'b1);
    rd_reg(2, 32'h6, "status_rx_valid");
    rd_reg(1, 32'h3C, "rxdata_3c");
    rd_reg(2, 32'h2, "status_rx_empty");
    for (int b = 1; b <= 5; b++) send_rx(8'(b), 1'b1);
    rd_reg(2, 32'hE, "status_overrun");
    rd_reg(2, 32'h6, "status_overrun_clr");
    for (int b = 1; b <= 4; b++) rd_reg(1, 32'(b), "rxdata_order");
    rd_reg(2, 32'h2, "status_rx_drained");
    send_rx(8'h5A, 1'b0);
    rd_reg(2, 32'h12, "status_frame_err");
    rd_reg(2, 32'h2, "status_fe_clr");
    wr_reg(3, 32'h1);
    cmp("irq_rx_en_empty", {31'd0, irq}, 32'd0);
    send_rx(8'h77, 1'b1);
    cmp("irq_rx_valid", {31'd0, irq}, 32'd1);
    rd_reg(1, 32'h77, "rxdata_77");
    cmp("irq_pop_lag", {31'd0, irq}, 32'd1);
    clks(1);
    cmp("irq_after_pop", {31'd0, irq}, 32'd0);
    wr_reg(3, 32'h2);
    cmp("irq_tx_en_lag", {31'd0, irq}, 32'd0);
    clks(1);
    cmp("irq_tx_idle", {31'd0, irq}, 32'd1);
    rd_reg(3, 32'h2, "ctrl_rd");
    wr_reg(3, 32'h0);
    clks(1);
    cmp("irq_disabled", {31'd0, irq}, 32'd0);
    uart_rx = 1'b0;
    clks(100);
    reset = 1'b0;
    clks(3);
    uart_rx = 1'b1;
    reset = 1'b1;
    clks(40);
    rd_reg(2, 32'h2, "status_after_reset");
    rd_reg(3, 32'h0, "ctrl_after_reset");
    cmp("uart_tx_after_reset", {31'd0, uart_tx}, 32'd1);
    send_rx(8'hC3, 1'b1);
    rd_reg(2, 32'h6, "status_post_reset_rx");
    rd_reg(1, 32'hC3, "rxdata_c3");
    clks(20);
    cmp("rd_queue_drained", 32'(q_rd.size()), 32'd0);
    cmp("tx_queue_drained", 32'(q_tx.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
